// File: rtl/spm_dma_pkg.sv
// Shared definitions for the scratchpad DMA engine: FSM state codes,
// configuration register offsets and CTRL register bit positions.
package spm_dma_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_WR   = 3'd2;
    localparam state_t ST_YLD  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_LEN_LO = 3'd4;
    localparam logic [2:0] REG_LEN_HI = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_FILL   = 3'd7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_DONE   = 4;

endpackage

// File: rtl/spm_dma_ctrl_regs.sv
// Wishbone slave and configuration register file of the DMA engine.
// Handshake: an access is taken when cyc & stb are high and ack is low;
// ack is registered, so every access is exactly two cycles and the write
// (or read data capture) happens on the edge that raises ack.
module spm_dma_ctrl_regs
    import spm_dma_pkg::*;
#(
    parameter int SPM_AWID = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          wb_adr,
    input  logic [7:0]          wb_dat_w,
    input  logic                wb_we,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    output logic [7:0]          wb_dat_r,
    output logic                wb_ack,
    input  logic                busy,
    input  logic                done_set,
    output logic                start,
    output logic                start_fill,
    output logic                abort,
    output logic [SPM_AWID-1:0] cfg_src,
    output logic [SPM_AWID-1:0] cfg_dst,
    output logic [15:0]         cfg_len,
    output logic [7:0]          cfg_fill,
    output logic                irq
);

    logic        access;
    logic        wr;
    logic        ctrl_wr;
    logic        cfg_wr;
    logic        mode;
    logic        irq_en;
    logic        done;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic [7:0]  rd_mux;

    assign access  = wb_cyc & wb_stb & ~wb_ack;
    assign wr      = access & wb_we;
    assign ctrl_wr = wr && (wb_adr == REG_CTRL);
    // Job parameters are frozen while a transfer runs.
    assign cfg_wr  = wr && !busy;

    // ABORT in the same write as START cancels the start.
    assign abort      = ctrl_wr & wb_dat_w[CTRL_ABORT];
    assign start      = ctrl_wr & wb_dat_w[CTRL_START] & ~wb_dat_w[CTRL_ABORT] & ~busy;
    assign start_fill = wb_dat_w[CTRL_MODE];

    assign src_ext = 16'(cfg_src);
    assign dst_ext = 16'(cfg_dst);
    assign irq     = done & irq_en;

    // Read multiplexer; address bits above the SPM width read as zero.
    always_comb begin
        rd_mux = 8'h00;
        case (wb_adr)
            REG_SRC_LO: rd_mux = src_ext[7:0];
            REG_SRC_HI: rd_mux = src_ext[15:8];
            REG_DST_LO: rd_mux = dst_ext[7:0];
            REG_DST_HI: rd_mux = dst_ext[15:8];
            REG_LEN_LO: rd_mux = cfg_len[7:0];
            REG_LEN_HI: rd_mux = cfg_len[15:8];
            REG_CTRL:   rd_mux = {3'b000, done, irq_en, 1'b0, mode, busy};
            REG_FILL:   rd_mux = cfg_fill;
            default:    rd_mux = 8'h00;
        endcase
    end

    // Bus handshake, register writes and DONE flag maintenance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_ack   <= 1'b0;
            wb_dat_r <= 8'h00;
            cfg_src  <= '0;
            cfg_dst  <= '0;
            cfg_len  <= 16'h0000;
            cfg_fill <= 8'h00;
            mode     <= 1'b0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
        end else begin
            wb_ack <= access;
            if (access) begin
                wb_dat_r <= rd_mux;
            end
            if (cfg_wr) begin
                case (wb_adr)
                    REG_SRC_LO: cfg_src  <= SPM_AWID'({src_ext[15:8], wb_dat_w});
                    REG_SRC_HI: cfg_src  <= SPM_AWID'({wb_dat_w, src_ext[7:0]});
                    REG_DST_LO: cfg_dst  <= SPM_AWID'({dst_ext[15:8], wb_dat_w});
                    REG_DST_HI: cfg_dst  <= SPM_AWID'({wb_dat_w, dst_ext[7:0]});
                    REG_LEN_LO: cfg_len  <= {cfg_len[15:8], wb_dat_w};
                    REG_LEN_HI: cfg_len  <= {wb_dat_w, cfg_len[7:0]};
                    REG_FILL:   cfg_fill <= wb_dat_w;
                    default:    ;
                endcase
            end
            if (ctrl_wr) begin
                mode   <= wb_dat_w[CTRL_MODE];
                irq_en <= wb_dat_w[CTRL_IRQ_EN];
            end
            if (start) begin
                done <= 1'b0;
            end else if (done_set) begin
                done <= 1'b1;
            end else if (ctrl_wr && wb_dat_w[CTRL_DONE]) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spm_dma_ctrl.sv
// Single-channel scratchpad DMA engine: copies a block inside the SPM
// (read one cycle, write the next) or fills it with a constant, yielding
// the SPM port for one cycle after every BURST_LEN bytes.
module spm_dma_ctrl
    import spm_dma_pkg::*;
#(
    parameter int SPM_DEPTH = 1024,
    parameter int SPM_AWID  = $clog2(SPM_DEPTH),
    parameter int BURST_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          WB_ADRi,
    input  logic [7:0]          WB_DATi,
    output logic [7:0]          WB_DATo,
    input  logic                WB_WEi,
    input  logic                WB_CYCi,
    input  logic                WB_STBi,
    output logic                WB_ACKo,
    output logic                dma_req,
    output logic [SPM_AWID-1:0] dmaaddr,
    output logic                we,
    output logic [7:0]          spm_dat_o,
    input  logic [7:0]          spm_dat_i,
    output logic                irq
);

    localparam logic [SPM_AWID-1:0] ADDR_ONE = 1;
    localparam logic [15:0]         BURST_W  = 16'(BURST_LEN);

    state_t              state;
    logic                start;
    logic                start_fill;
    logic                abort;
    logic                busy;
    logic                done_set;
    logic                fill_mode;
    logic                burst_hit;
    logic [SPM_AWID-1:0] cfg_src;
    logic [SPM_AWID-1:0] cfg_dst;
    logic [15:0]         cfg_len;
    logic [7:0]          cfg_fill;
    logic [SPM_AWID-1:0] src_cnt;
    logic [SPM_AWID-1:0] dst_cnt;
    logic [15:0]         rem;
    logic [15:0]         burst_cnt;

    spm_dma_ctrl_regs #(
        .SPM_AWID (SPM_AWID)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .wb_adr     (WB_ADRi),
        .wb_dat_w   (WB_DATi),
        .wb_we      (WB_WEi),
        .wb_cyc     (WB_CYCi),
        .wb_stb     (WB_STBi),
        .wb_dat_r   (WB_DATo),
        .wb_ack     (WB_ACKo),
        .busy       (busy),
        .done_set   (done_set),
        .start      (start),
        .start_fill (start_fill),
        .abort      (abort),
        .cfg_src    (cfg_src),
        .cfg_dst    (cfg_dst),
        .cfg_len    (cfg_len),
        .cfg_fill   (cfg_fill),
        .irq        (irq)
    );

    assign busy      = (state != ST_IDLE);
    // An abort while in DONE leaves the DONE flag untouched.
    assign done_set  = (state == ST_DONE) && !abort;
    assign burst_hit = (BURST_LEN != 0) && ((burst_cnt + 16'd1) == BURST_W);

    assign dma_req   = (state == ST_RD) || (state == ST_WR);
    assign we        = (state == ST_WR);
    // In copy mode the byte fetched in RD arrives on spm_dat_i during WR.
    assign spm_dat_o = fill_mode ? cfg_fill : spm_dat_i;

    // SPM address: source while reading, destination while writing.
    always_comb begin
        dmaaddr = '0;
        if (state == ST_RD) begin
            dmaaddr = src_cnt;
        end else if (state == ST_WR) begin
            dmaaddr = dst_cnt;
        end
    end

    // Transfer FSM with working counters; counters wrap with the SPM size.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            src_cnt   <= '0;
            dst_cnt   <= '0;
            rem       <= 16'h0000;
            burst_cnt <= 16'h0000;
            fill_mode <= 1'b0;
        end else if (abort && busy) begin
            state     <= ST_IDLE;
            burst_cnt <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_cnt   <= cfg_src;
                        dst_cnt   <= cfg_dst;
                        rem       <= cfg_len;
                        burst_cnt <= 16'h0000;
                        fill_mode <= start_fill;
                        if (cfg_len == 16'h0000) begin
                            state <= ST_DONE;
                        end else begin
                            state <= start_fill ? ST_WR : ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WR;
                end
                ST_WR: begin
                    if (!fill_mode) begin
                        src_cnt <= src_cnt + ADDR_ONE;
                    end
                    dst_cnt   <= dst_cnt + ADDR_ONE;
                    rem       <= rem - 16'd1;
                    burst_cnt <= burst_cnt + 16'd1;
                    if (rem == 16'd1) begin
                        state <= ST_DONE;
                    end else if (burst_hit) begin
                        state <= ST_YLD;
                    end else begin
                        state <= fill_mode ? ST_WR : ST_RD;
                    end
                end
                ST_YLD: begin
                    burst_cnt <= 16'h0000;
                    state     <= fill_mode ? ST_WR : ST_RD;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_dma_ctrl.sv
// Bench for spm_dma_ctrl: drives the Wishbone config port, models the
// scratchpad, and compares the SPM contents and port activity against a
// byte-level model of each job.
module tb_spm_dma_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int BL    = 16;

    localparam logic [2:0] A_SRC_LO = 3'd0;
    localparam logic [2:0] A_SRC_HI = 3'd1;
    localparam logic [2:0] A_DST_LO = 3'd2;
    localparam logic [2:0] A_DST_HI = 3'd3;
    localparam logic [2:0] A_LEN_LO = 3'd4;
    localparam logic [2:0] A_LEN_HI = 3'd5;
    localparam logic [2:0] A_CTRL   = 3'd6;
    localparam logic [2:0] A_FILL   = 3'd7;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2:0]    WB_ADRi = 3'd0;
    logic [7:0]    WB_DATi = 8'h00;
    logic [7:0]    WB_DATo;
    logic          WB_WEi  = 1'b0;
    logic          WB_CYCi = 1'b0;
    logic          WB_STBi = 1'b0;
    logic          WB_ACKo;
    logic          dma_req;
    logic [AW-1:0] dmaaddr;
    logic          we;
    logic [7:0]    spm_dat_o;
    logic [7:0]    spm_dat_i;
    logic          irq;

    always #5 clk = ~clk;

    spm_dma_ctrl #(
        .SPM_DEPTH (DEPTH),
        .BURST_LEN (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .WB_ADRi   (WB_ADRi),
        .WB_DATi   (WB_DATi),
        .WB_DATo   (WB_DATo),
        .WB_WEi    (WB_WEi),
        .WB_CYCi   (WB_CYCi),
        .WB_STBi   (WB_STBi),
        .WB_ACKo   (WB_ACKo),
        .dma_req   (dma_req),
        .dmaaddr   (dmaaddr),
        .we        (we),
        .spm_dat_o (spm_dat_o),
        .spm_dat_i (spm_dat_i),
        .irq       (irq)
    );

    // ---------------- scratchpad model ----------------
    logic [7:0] spm_mem  [0:DEPTH-1];
    logic [7:0] load_img [0:DEPTH-1];
    logic [7:0] exp_mem  [0:DEPTH-1];
    logic       mem_load = 1'b0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) spm_mem[i] <= load_img[i];
        end else if (we) begin
            spm_mem[dmaaddr] <= spm_dat_o;
        end
        spm_dat_i <= spm_mem[dmaaddr];
    end

    // ---------------- port activity monitor ----------------
    int         cnt_req   = 0;
    int         cnt_we    = 0;
    int         bad_we    = 0;
    int         low_run   = 0;
    int         we_at_low = 0;
    logic       seen      = 1'b0;
    int         gap_len_q[$];
    int         gap_we_q[$];
    logic       mon_clr   = 1'b0;
    logic       cpu_req   = 1'b0;
    logic       cpu_done  = 1'b0;
    int         cpu_we    = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            cnt_req = 0;
            cnt_we  = 0;
            low_run = 0;
            seen    = 1'b0;
            gap_len_q.delete();
            gap_we_q.delete();
            cpu_done = 1'b0;
            cpu_we   = 0;
        end else begin
            if (we && !dma_req) bad_we++;
            if (we) cnt_we++;
            if (dma_req) begin
                cnt_req++;
                if (seen && low_run > 0) begin
                    gap_len_q.push_back(low_run);
                    gap_we_q.push_back(we_at_low);
                end
                low_run = 0;
                seen    = 1'b1;
            end else if (seen) begin
                if (low_run == 0) we_at_low = cnt_we;
                low_run++;
            end
            // A CPU SPM access is only acknowledged while the engine is off the port.
            if (cpu_req && !cpu_done && !dma_req) begin
                cpu_done = 1'b1;
                cpu_we   = cnt_we;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fails  = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wb_cycle(input logic [2:0] a, input logic w, input logic [7:0] d,
                            output logic [7:0] q);
        int n;
        if (WB_ACKo) begin
            @(posedge clk);
            #1;
        end
        WB_ADRi = a;
        WB_DATi = d;
        WB_WEi  = w;
        WB_CYCi = 1'b1;
        WB_STBi = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!WB_ACKo && n < 8);
        check("wb_ack_latency", n, 1);
        q = WB_DATo;
        WB_CYCi = 1'b0;
        WB_STBi = 1'b0;
        WB_WEi  = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        wb_cycle(a, 1'b1, d, q);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [7:0] q);
        wb_cycle(a, 1'b0, 8'h00, q);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic program_regs(input int s, input int d, input int l, input logic [7:0] f);
        wb_write(A_SRC_LO, 8'(s));
        wb_write(A_SRC_HI, 8'(s >> 8));
        wb_write(A_DST_LO, 8'(d));
        wb_write(A_DST_HI, 8'(d >> 8));
        wb_write(A_LEN_LO, 8'(l));
        wb_write(A_LEN_HI, 8'(l >> 8));
        wb_write(A_FILL, f);
    endtask

    task automatic wait_idle(input string tag, output logic [7:0] q);
        int n;
        n = 0;
        do begin
            wb_read(A_CTRL, q);
            n++;
        end while (q[0] && n < 400);
        check({tag, "_finish_timeout"}, 32'(q[0]), 0);
    endtask

    task automatic mem_compare(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (spm_mem[i] !== exp_mem[i]) mism++;
        check({tag, "_mem_mismatches"}, mism, 0);
    endtask

    // One complete job: program, start, wait, then compare against the byte model.
    task automatic run_job(input string tag, input int s, input int d, input int l,
                           input logic fm, input logic [7:0] fv, input logic ie,
                           input logic with_cpu);
        logic [7:0] q;
        program_regs(s, d, l, fv);
        clear_mon();
        wb_write(A_CTRL, {4'b0000, ie, 1'b0, fm, 1'b1});
        if (with_cpu) cpu_req = 1'b1;
        wait_idle(tag, q);
        cpu_req = 1'b0;
        for (int i = 0; i < l; i++) begin
            exp_mem[(d + i) % DEPTH] = fm ? fv : exp_mem[(s + i) % DEPTH];
        end
        mem_compare(tag);
        check({tag, "_req_cycles"}, cnt_req, fm ? l : 2 * l);
        check({tag, "_we_cycles"}, cnt_we, l);
        exp_q.delete();
        for (int k = BL; k < l; k += BL) exp_q.push_back(16'(k));
        check({tag, "_yield_count"}, gap_we_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < gap_we_q.size()) begin
                check({tag, "_yield_pos"}, gap_we_q[i], 32'(exp_q[i]));
                check({tag, "_yield_len"}, gap_len_q[i], 1);
            end
        end
        check({tag, "_ctrl"}, 32'(q), 32'({3'b000, 1'b1, ie, 1'b0, fm, 1'b0}));
        check({tag, "_irq"}, 32'(irq), 32'(ie));
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [7:0] q;
        logic [7:0] pat [0:3];
        int         s, d, l;
        logic       fm, ie;
        logic [7:0] fv;

        pat[0] = 8'hAA; pat[1] = 8'hBB; pat[2] = 8'hCC; pat[3] = 8'hDD;
        for (int i = 0; i < DEPTH; i++) load_img[i] = 8'($urandom_range(255, 0));
        for (int i = 0; i < 4; i++) load_img[16'h010 + i] = pat[i];
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = load_img[i];

        // Reset with the SPM image loading in parallel.
        mem_load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;
        check("reset_dma_req", 32'(dma_req), 0);
        check("reset_we", 32'(we), 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_ack", 32'(WB_ACKo), 0);
        check("reset_dmaaddr", 32'(dmaaddr), 0);
        rst = 1'b1;
        clear_mon();

        // Directed copy with IRQ enabled.
        run_job("copy", 16'h010, 16'h200, 4, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) check("copy_dst_byte", 32'(spm_mem[16'h200 + i]), 32'(pat[i]));

        // Write-one-clears DONE (this write also drops IRQ_EN).
        wb_write(A_CTRL, 8'h10);
        wb_read(A_CTRL, q);
        check("w1c_ctrl", 32'(q), 0);
        check("w1c_irq", 32'(irq), 0);

        // Directed fill wrapping past the top of the SPM.
        run_job("fill", 0, 16'h3FE, 4, 1'b1, 8'h5A, 1'b0, 1'b0);
        check("fill_3fe", 32'(spm_mem[10'h3FE]), 32'h5A);
        check("fill_3ff", 32'(spm_mem[10'h3FF]), 32'h5A);
        check("fill_000", 32'(spm_mem[10'h000]), 32'h5A);
        check("fill_001", 32'(spm_mem[10'h001]), 32'h5A);

        // Zero-length job: DONE two cycles after START, port never claimed.
        program_regs(0, 0, 0, 8'h00);
        clear_mon();
        wb_write(A_CTRL, 8'h09);
        check("len0_irq_early", 32'(irq), 0);
        @(posedge clk);
        #1;
        check("len0_irq_done", 32'(irq), 1);
        wb_read(A_CTRL, q);
        check("len0_ctrl", 32'(q), 32'h18);
        check("len0_req_cycles", cnt_req, 0);

        // Long fill with yields and a concurrent CPU SPM access.
        run_job("yield", 0, 16'h100, 40, 1'b1, 8'hC3, 1'b0, 1'b1);
        check("yield_cpu_acked", 32'(cpu_done), 1);
        check("yield_cpu_ack_pos", cpu_we, BL);

        // Random jobs, including overlapping copies and address wrap.
        for (int j = 0; j < 6; j++) begin
            s  = $urandom_range(DEPTH - 1, 0);
            d  = $urandom_range(DEPTH - 1, 0);
            l  = $urandom_range(40, 1);
            fm = 1'($urandom_range(1, 0));
            ie = 1'($urandom_range(1, 0));
            fv = 8'($urandom_range(255, 0));
            run_job("rand", s, d, l, fm, fv, ie, 1'b0);
        end

        // Abort after the third of ten copy bytes; SRC write while busy is dropped.
        program_regs(16'h040, 16'h300, 10, 8'h00);
        clear_mon();
        wb_write(A_CTRL, 8'h01);
        wb_write(A_SRC_LO, 8'h77);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        wb_write(A_CTRL, 8'h04);
        check("abort_dma_req", 32'(dma_req), 0);
        wb_read(A_CTRL, q);
        check("abort_ctrl", 32'(q), 0);
        check("abort_we_cycles", cnt_we, 3);
        for (int i = 0; i < 3; i++) exp_mem[16'h300 + i] = exp_mem[16'h040 + i];
        mem_compare("abort");
        wb_read(A_SRC_LO, q);
        check("busy_src_write_dropped", 32'(q), 32'h40);

        check("we_without_req", bad_we, 0);

        // Reset in the middle of a copy.
        program_regs(0, 16'h080, 20, 8'h00);
        wb_write(A_CTRL, 8'h09);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_dma_req", 32'(dma_req), 0);
        check("midreset_we", 32'(we), 0);
        rst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), q);
            check("midreset_reg", 32'(q), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
